// File: rtl/risc16_ctrl_fsm_if.sv
// Control bundle between the RiSC-16 sequencer and its datapath/memories.
// The controller is the master: it issues strobes and requests. The datapath
// side is the slave: it returns the IR contents, the acks and the ALU compare.
interface risc16_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  logic [15:0]      ir;
  logic             imem_ack;
  logic             dmem_ack;
  logic             alu_eq;

  logic             imem_req;
  logic             WE_ir;
  logic             WE_opnd;
  logic             MUX_rf;
  logic             MUX_alu1;
  logic             MUX_alu2;
  logic [1:0]       FUNC_alu;
  logic             dmem_req;
  logic             dmem_we;
  logic             WE_rf;
  logic [1:0]       MUX_tgt;
  logic             WE_pc;
  logic [1:0]       MUX_pc;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  ir, imem_ack, dmem_ack, alu_eq,
    output imem_req, WE_ir, WE_opnd, MUX_rf, MUX_alu1, MUX_alu2, FUNC_alu,
           dmem_req, dmem_we, WE_rf, MUX_tgt, WE_pc, MUX_pc, halted, retired
  );

  modport slave (
    output ir, imem_ack, dmem_ack, alu_eq,
    input  imem_req, WE_ir, WE_opnd, MUX_rf, MUX_alu1, MUX_alu2, FUNC_alu,
           dmem_req, dmem_we, WE_rf, MUX_tgt, WE_pc, MUX_pc, halted, retired
  );
endinterface

// File: rtl/risc16_ctrl_fsm.sv
// Multi-cycle control sequencer for the RiSC-16 datapath.
// Walks FETCH -> DECODE -> EXEC -> MEM -> WB per instruction, drives the
// datapath strobes as a decode of state and opcode, counts retired
// instructions and parks in HALT when the halt word is decoded.
module risc16_ctrl_fsm #(
  parameter int          CNT_W     = 32,
  parameter logic [15:0] HALT_WORD = 16'hE071
) (
  input logic               clk,
  input logic               rst,
  risc16_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] retired_q;

  logic [2:0] op;
  logic [2:0] ra;
  logic       is_halt;

  logic       imem_req;
  logic       we_ir;
  logic       we_opnd;
  logic       mux_rf;
  logic       mux_alu1;
  logic       mux_alu2;
  logic [1:0] func_alu;
  logic       dmem_req;
  logic       dmem_we;
  logic       we_rf;
  logic [1:0] mux_tgt;
  logic       we_pc;
  logic [1:0] mux_pc;
  logic       halted;
  logic       retire;

  assign op      = bus.ir[15:13];
  assign ra      = bus.ir[12:10];
  assign is_halt = (bus.ir == HALT_WORD);

  // State register; reset parks the sequencer at FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state decode; acks only matter in the two states that hold a request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (bus.imem_ack) state_d = DECODE;
      DECODE: begin
        if (is_halt)             state_d = HALT;
        else if (op == OP_JALR)  state_d = WB;
        else                     state_d = EXEC;
      end
      EXEC: begin
        if (op == OP_BEQ)                      state_d = FETCH;
        else if (op == OP_LW || op == OP_SW)   state_d = MEM;
        else                                   state_d = WB;
      end
      MEM: begin
        if (bus.dmem_ack) state_d = (op == OP_SW) ? FETCH : WB;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Strobe decode; everything is forced low while reset is held so no
  // partial register or PC write can leak out of an aborted instruction.
  always_comb begin
    imem_req = 1'b0;
    we_ir    = 1'b0;
    we_opnd  = 1'b0;
    mux_rf   = 1'b0;
    mux_alu1 = 1'b0;
    mux_alu2 = 1'b0;
    func_alu = 2'b00;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    we_rf    = 1'b0;
    mux_tgt  = 2'b00;
    we_pc    = 1'b0;
    mux_pc   = 2'b00;
    halted   = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          we_ir    = bus.imem_ack;
        end
        DECODE: begin
          we_opnd = 1'b1;
          mux_rf  = (op == OP_SW) || (op == OP_BEQ);
        end
        EXEC: begin
          case (op)
            OP_ADD:  func_alu = 2'b00;
            OP_ADDI: begin func_alu = 2'b00; mux_alu2 = 1'b1; end
            OP_NAND: func_alu = 2'b01;
            OP_LUI:  begin func_alu = 2'b10; mux_alu1 = 1'b1; end
            OP_LW,
            OP_SW:   begin func_alu = 2'b00; mux_alu2 = 1'b1; end
            OP_BEQ: begin
              func_alu = 2'b11;
              we_pc    = 1'b1;
              mux_pc   = bus.alu_eq ? 2'b01 : 2'b00;
            end
            default: func_alu = 2'b00;
          endcase
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (op == OP_SW);
          if (bus.dmem_ack && op == OP_SW) we_pc = 1'b1;
        end
        WB: begin
          we_rf   = (ra != 3'd0);
          mux_tgt = (op == OP_LW) ? 2'b00 : (op == OP_JALR) ? 2'b10 : 2'b01;
          we_pc   = 1'b1;
          mux_pc  = (op == OP_JALR) ? 2'b10 : 2'b00;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign retire = we_pc || (state_q == DECODE && state_d == HALT);

  // Retired-instruction counter; the halt instruction counts once on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  assign bus.imem_req = imem_req;
  assign bus.WE_ir    = we_ir;
  assign bus.WE_opnd  = we_opnd;
  assign bus.MUX_rf   = mux_rf;
  assign bus.MUX_alu1 = mux_alu1;
  assign bus.MUX_alu2 = mux_alu2;
  assign bus.FUNC_alu = func_alu;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_we;
  assign bus.WE_rf    = we_rf;
  assign bus.MUX_tgt  = mux_tgt;
  assign bus.WE_pc    = we_pc;
  assign bus.MUX_pc   = mux_pc;
  assign bus.halted   = halted;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// Directed bench for the RiSC-16 control sequencer. Each cycle's inputs and
// the strobes expected for that cycle are queued together, then replayed one
// clock at a time and compared at the falling edge.
module tb_risc16_ctrl_fsm;

  logic clk;
  logic rst;

  risc16_ctrl_fsm_if #(.CNT_W(32)) bus ();

  risc16_ctrl_fsm #(.CNT_W(32), .HALT_WORD(16'hE071)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       imem_req;
    logic       we_ir;
    logic       we_opnd;
    logic       mux_rf;
    logic       mux_alu1;
    logic       mux_alu2;
    logic [1:0] func_alu;
    logic       dmem_req;
    logic       dmem_we;
    logic       we_rf;
    logic [1:0] mux_tgt;
    logic       we_pc;
    logic [1:0] mux_pc;
    logic       halted;
  } vec_t;

  typedef struct {
    logic [15:0] ir;
    logic        imem_ack;
    logic        dmem_ack;
    logic        alu_eq;
    vec_t        exp;
    logic [31:0] ret;
  } entry_t;

  entry_t      sb[$];
  string       tag_q[$];
  int          n_cmp;
  int          n_fail;
  logic [31:0] tb_retired;

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t v_idle();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t v_fetch(logic ack);
    vec_t v;
    v = '0;
    v.imem_req = 1'b1;
    v.we_ir    = ack;
    return v;
  endfunction

  function automatic vec_t v_decode(logic mux_rf);
    vec_t v;
    v = '0;
    v.we_opnd = 1'b1;
    v.mux_rf  = mux_rf;
    return v;
  endfunction

  function automatic vec_t v_exec(logic [1:0] f, logic a1, logic a2);
    vec_t v;
    v = '0;
    v.func_alu = f;
    v.mux_alu1 = a1;
    v.mux_alu2 = a2;
    return v;
  endfunction

  function automatic vec_t v_beq(logic taken);
    vec_t v;
    v = '0;
    v.func_alu = 2'b11;
    v.we_pc    = 1'b1;
    v.mux_pc   = taken ? 2'b01 : 2'b00;
    return v;
  endfunction

  function automatic vec_t v_mem(logic store, logic sw_done);
    vec_t v;
    v = '0;
    v.dmem_req = 1'b1;
    v.dmem_we  = store;
    v.we_pc    = sw_done;
    return v;
  endfunction

  function automatic vec_t v_wb(logic we_rf, logic [1:0] tgt, logic [1:0] pc);
    vec_t v;
    v = '0;
    v.we_rf   = we_rf;
    v.mux_tgt = tgt;
    v.we_pc   = 1'b1;
    v.mux_pc  = pc;
    return v;
  endfunction

  function automatic vec_t v_halt();
    vec_t v;
    v = '0;
    v.halted = 1'b1;
    return v;
  endfunction

  function automatic vec_t observe();
    vec_t v;
    v.imem_req = bus.imem_req;
    v.we_ir    = bus.WE_ir;
    v.we_opnd  = bus.WE_opnd;
    v.mux_rf   = bus.MUX_rf;
    v.mux_alu1 = bus.MUX_alu1;
    v.mux_alu2 = bus.MUX_alu2;
    v.func_alu = bus.FUNC_alu;
    v.dmem_req = bus.dmem_req;
    v.dmem_we  = bus.dmem_we;
    v.we_rf    = bus.WE_rf;
    v.mux_tgt  = bus.MUX_tgt;
    v.we_pc    = bus.WE_pc;
    v.mux_pc   = bus.MUX_pc;
    v.halted   = bus.halted;
    return v;
  endfunction

  task automatic applyStimulus(input string tag, input logic [15:0] ir,
                               input logic ia, input logic da, input logic eq,
                               input vec_t exp);
    entry_t e;
    e.ir       = ir;
    e.imem_ack = ia;
    e.dmem_ack = da;
    e.alu_eq   = eq;
    e.exp      = exp;
    e.ret      = tb_retired;
    sb.push_back(e);
    tag_q.push_back(tag);
    if (exp.we_pc) tb_retired = tb_retired + 32'd1;
  endtask

  task automatic checkOutput(input string tag, input vec_t exp, input logic [31:0] ret);
    vec_t obs;
    obs = observe();
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s strobes observed=%h expected=%h", tag, obs, exp);
    end
    n_cmp++;
    assert (bus.retired === ret) else begin
      n_fail++;
      $error("[TB] FAIL %s_retired observed=%0d expected=%0d", tag, bus.retired, ret);
    end
  endtask

  task automatic runQueue();
    entry_t e;
    string  t;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      t = tag_q.pop_front();
      bus.ir       = e.ir;
      bus.imem_ack = e.imem_ack;
      bus.dmem_ack = e.dmem_ack;
      bus.alu_eq   = e.alu_eq;
      @(negedge clk);
      checkOutput(t, e.exp, e.ret);
      @(posedge clk);
      #1;
    end
  endtask

  // Directed sequence: reset, each instruction class, waits, async reset, halt.
  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    tb_retired   = 32'd0;
    rst          = 1'b1;
    bus.ir       = 16'h0000;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    bus.alu_eq   = 1'b0;
    #3;
    checkOutput("reset_state", v_idle(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // add r1,r2,r3 with zero-wait fetch; stray dmem_ack must be ignored
    applyStimulus("add_fetch",  16'h0503, 1, 1, 0, v_fetch(1));
    applyStimulus("add_decode", 16'h0503, 1, 1, 0, v_decode(0));
    applyStimulus("add_exec",   16'h0503, 1, 1, 0, v_exec(2'b00, 0, 0));
    applyStimulus("add_wb",     16'h0503, 1, 1, 0, v_wb(1, 2'b01, 2'b00));
    // lw r2,r1,5 with three dmem wait cycles
    applyStimulus("lw_fetch",   16'h8885, 1, 0, 0, v_fetch(1));
    applyStimulus("lw_decode",  16'h8885, 1, 0, 0, v_decode(0));
    applyStimulus("lw_exec",    16'h8885, 1, 0, 0, v_exec(2'b00, 0, 1));
    applyStimulus("lw_mem_w1",  16'h8885, 1, 0, 0, v_mem(0, 0));
    applyStimulus("lw_mem_w2",  16'h8885, 1, 0, 0, v_mem(0, 0));
    applyStimulus("lw_mem_w3",  16'h8885, 1, 0, 0, v_mem(0, 0));
    applyStimulus("lw_mem_ack", 16'h8885, 1, 1, 0, v_mem(0, 0));
    applyStimulus("lw_wb",      16'h8885, 0, 0, 0, v_wb(1, 2'b00, 2'b00));
    // beq taken, preceded by one imem wait cycle
    applyStimulus("beq1_fwait",  16'hC4FE, 0, 0, 1, v_fetch(0));
    applyStimulus("beq1_fetch",  16'hC4FE, 1, 0, 1, v_fetch(1));
    applyStimulus("beq1_decode", 16'hC4FE, 1, 0, 1, v_decode(1));
    applyStimulus("beq1_exec",   16'hC4FE, 1, 0, 1, v_beq(1));
    // beq not taken
    applyStimulus("beq0_fetch",  16'hC4FE, 1, 0, 0, v_fetch(1));
    applyStimulus("beq0_decode", 16'hC4FE, 1, 0, 0, v_decode(1));
    applyStimulus("beq0_exec",   16'hC4FE, 1, 0, 0, v_beq(0));
    // add r0,r1,r2: r0 is never written
    applyStimulus("addr0_fetch",  16'h0082, 1, 0, 0, v_fetch(1));
    applyStimulus("addr0_decode", 16'h0082, 1, 0, 0, v_decode(0));
    applyStimulus("addr0_exec",   16'h0082, 1, 0, 0, v_exec(2'b00, 0, 0));
    applyStimulus("addr0_wb",     16'h0082, 1, 0, 0, v_wb(0, 2'b01, 2'b00));
    // jalr r3,r3
    applyStimulus("jalr_fetch",  16'hED80, 1, 0, 0, v_fetch(1));
    applyStimulus("jalr_decode", 16'hED80, 1, 0, 0, v_decode(0));
    applyStimulus("jalr_wb",     16'hED80, 1, 0, 0, v_wb(1, 2'b10, 2'b10));
    // addi r1,r2,5
    applyStimulus("addi_fetch",  16'h2505, 1, 0, 0, v_fetch(1));
    applyStimulus("addi_decode", 16'h2505, 1, 0, 0, v_decode(0));
    applyStimulus("addi_exec",   16'h2505, 1, 0, 0, v_exec(2'b00, 0, 1));
    applyStimulus("addi_wb",     16'h2505, 1, 0, 0, v_wb(1, 2'b01, 2'b00));
    // nand r1,r2,r3
    applyStimulus("nand_fetch",  16'h4503, 1, 0, 0, v_fetch(1));
    applyStimulus("nand_decode", 16'h4503, 1, 0, 0, v_decode(0));
    applyStimulus("nand_exec",   16'h4503, 1, 0, 0, v_exec(2'b01, 0, 0));
    applyStimulus("nand_wb",     16'h4503, 1, 0, 0, v_wb(1, 2'b01, 2'b00));
    // sw r1,r2,3 zero-wait
    applyStimulus("sw_fetch",  16'hA503, 1, 1, 0, v_fetch(1));
    applyStimulus("sw_decode", 16'hA503, 1, 1, 0, v_decode(1));
    applyStimulus("sw_exec",   16'hA503, 1, 1, 0, v_exec(2'b00, 0, 1));
    applyStimulus("sw_mem",    16'hA503, 1, 1, 0, v_mem(1, 1));
    // sw again, stalled in MEM and then aborted by reset
    applyStimulus("swr_fetch",  16'hA503, 1, 0, 0, v_fetch(1));
    applyStimulus("swr_decode", 16'hA503, 1, 0, 0, v_decode(1));
    applyStimulus("swr_exec",   16'hA503, 1, 0, 0, v_exec(2'b00, 0, 1));
    runQueue();

    bus.dmem_ack = 1'b0;
    @(negedge clk);
    checkOutput("swr_mem_wait", v_mem(1, 0), tb_retired);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_drop", v_idle(), 32'd0);
    tb_retired = 32'd0;
    @(posedge clk);
    #1;
    checkOutput("rst_held", v_idle(), 32'd0);
    bus.imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("rst_release_fetch", v_fetch(0), 32'd0);
    @(posedge clk);
    #1;

    // halt word, then a long idle window with acks asserted
    applyStimulus("halt_fetch",  16'hE071, 1, 1, 0, v_fetch(1));
    applyStimulus("halt_decode", 16'hE071, 1, 1, 0, v_decode(0));
    tb_retired = tb_retired + 32'd1;
    for (int i = 0; i < 20; i++)
      applyStimulus($sformatf("halt_idle%0d", i), 16'hE071, 1, 1, 0, v_halt());
    runQueue();

    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    rst = 1'b0;
    tb_retired = 32'd0;
    #1;
    checkOutput("halt_cleared_by_rst", v_fetch(0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
